// File: rtl/tcp_app_pkg.sv
// Shared constants for the TCP application TX handshake: status codes,
// metadata/status word field offsets and responder FSM state encodings.
package tcp_app_pkg;

    localparam logic [1:0] CODE_OK      = 2'd0;
    localparam logic [1:0] CODE_NOCONN  = 2'd1;
    localparam logic [1:0] CODE_NOSPACE = 2'd2;
    localparam logic [1:0] CODE_INVALID = 2'd3;

    localparam int META_SESS_LSB = 0;
    localparam int META_LEN_LSB  = 16;

    localparam int STAT_SESS_LSB  = 0;
    localparam int STAT_LEN_LSB   = 16;
    localparam int STAT_SPACE_LSB = 32;
    localparam int STAT_CODE_LSB  = 62;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STATUS = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;

endpackage

// File: rtl/tkeep_popcount.sv
// Counts the valid bytes of a 512-bit AXI-Stream beat from its TKEEP mask.
module tkeep_popcount (
    input  logic [63:0] tkeep,
    output logic [6:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 64; i++) begin
            count = count + {6'd0, tkeep[i]};
        end
    end

endmodule

// File: rtl/tcp_app_tx_responder.sv
// Stack-side stand-in for the TCP TX app interface: grants metadata requests,
// answers with a status word and forwards (or drops) one data packet per grant.
module tcp_app_tx_responder
    import tcp_app_pkg::*;
#(
    parameter int NUM_SESSIONS = 16,
    parameter int BUF_BYTES    = 65536,
    parameter int MAX_LEN      = 1408
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [NUM_SESSIONS-1:0] session_open,
    input  logic [31:0]             s_axis_tx_metadata_tdata,
    input  logic                    s_axis_tx_metadata_tvalid,
    output logic                    s_axis_tx_metadata_tready,
    output logic [63:0]             m_axis_tx_status_tdata,
    output logic                    m_axis_tx_status_tvalid,
    input  logic                    m_axis_tx_status_tready,
    input  logic [511:0]            s_axis_tx_data_tdata,
    input  logic [63:0]             s_axis_tx_data_tkeep,
    input  logic                    s_axis_tx_data_tlast,
    input  logic                    s_axis_tx_data_tvalid,
    output logic                    s_axis_tx_data_tready,
    output logic [511:0]            m_axis_out_tdata,
    output logic [63:0]             m_axis_out_tkeep,
    output logic                    m_axis_out_tlast,
    output logic                    m_axis_out_tvalid,
    input  logic                    m_axis_out_tready,
    output logic [15:0]             m_out_session,
    input  logic                    free_valid,
    input  logic [15:0]             free_bytes,
    output logic [31:0]             pkt_ok_cnt,
    output logic [31:0]             pkt_err_cnt,
    output logic                    len_mismatch
);

    localparam int          SIDX_W     = $clog2(NUM_SESSIONS);
    localparam logic [16:0] NUM_SESS_W = 17'(NUM_SESSIONS);
    localparam logic [15:0] MAX_LEN_W  = 16'(MAX_LEN);
    localparam logic [31:0] BUF_W      = 32'(BUF_BYTES);

    logic [1:0]  state;
    logic        fwd;
    logic [15:0] sess_q;
    logic [15:0] len_q;
    logic [1:0]  code_q;
    logic [29:0] space;
    logic [29:0] stat_space;
    logic [16:0] bytecnt;
    logic [16:0] bytecnt_final;
    logic [6:0]  beat_bytes;
    logic [31:0] space_sum;
    logic [15:0] meta_sess;
    logic [15:0] meta_len;
    logic [1:0]  code_next;
    logic        meta_acc;
    logic        stat_acc;
    logic        beat_acc;

    tkeep_popcount u_popcount (
        .tkeep (s_axis_tx_data_tkeep),
        .count (beat_bytes)
    );

    assign meta_sess     = s_axis_tx_metadata_tdata[META_SESS_LSB +: 16];
    assign meta_len      = s_axis_tx_metadata_tdata[META_LEN_LSB +: 16];
    assign bytecnt_final = bytecnt + {10'd0, beat_bytes};

    // Every handshake output is forced low while reset is held, even before the state clears.
    assign s_axis_tx_metadata_tready = aresetn && (state == S_IDLE);
    assign m_axis_tx_status_tvalid   = aresetn && (state == S_STATUS);
    assign s_axis_tx_data_tready     = aresetn && (state == S_DATA) && (fwd ? m_axis_out_tready : 1'b1);
    assign m_axis_out_tvalid         = aresetn && (state == S_DATA) && fwd && s_axis_tx_data_tvalid;
    assign m_axis_out_tdata          = s_axis_tx_data_tdata;
    assign m_axis_out_tkeep          = s_axis_tx_data_tkeep;
    assign m_axis_out_tlast          = s_axis_tx_data_tlast;
    assign m_out_session             = sess_q;

    assign meta_acc = s_axis_tx_metadata_tvalid && s_axis_tx_metadata_tready;
    assign stat_acc = m_axis_tx_status_tvalid && m_axis_tx_status_tready;
    assign beat_acc = s_axis_tx_data_tvalid && s_axis_tx_data_tready;

    always_comb begin
        m_axis_tx_status_tdata = '0;
        m_axis_tx_status_tdata[STAT_SESS_LSB +: 16]  = sess_q;
        m_axis_tx_status_tdata[STAT_LEN_LSB +: 16]   = len_q;
        m_axis_tx_status_tdata[STAT_SPACE_LSB +: 30] = stat_space;
        m_axis_tx_status_tdata[STAT_CODE_LSB +: 2]   = code_q;
    end

    // Invalid length outranks a missing connection, which outranks lack of space.
    always_comb begin
        code_next = CODE_OK;
        if (meta_len == 16'd0 || meta_len > MAX_LEN_W) begin
            code_next = CODE_INVALID;
        end else if ({1'b0, meta_sess} >= NUM_SESS_W || !session_open[meta_sess[SIDX_W-1:0]]) begin
            code_next = CODE_NOCONN;
        end else if ({16'd0, meta_len} > {2'd0, space}) begin
            code_next = CODE_NOSPACE;
        end
    end

    // The grant never exceeds space seen at metadata time and space only grows meanwhile.
    always_comb begin
        space_sum = {2'd0, space};
        if (free_valid) begin
            space_sum = space_sum + {16'd0, free_bytes};
        end
        if (stat_acc && code_q == CODE_OK) begin
            space_sum = space_sum - {16'd0, len_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state        <= S_IDLE;
            fwd          <= 1'b0;
            sess_q       <= '0;
            len_q        <= '0;
            code_q       <= CODE_OK;
            stat_space   <= '0;
            space        <= BUF_W[29:0];
            bytecnt      <= '0;
            pkt_ok_cnt   <= '0;
            pkt_err_cnt  <= '0;
            len_mismatch <= 1'b0;
        end else begin
            space <= (space_sum > BUF_W) ? BUF_W[29:0] : space_sum[29:0];
            case (state)
                S_IDLE: begin
                    if (meta_acc) begin
                        sess_q     <= meta_sess;
                        len_q      <= meta_len;
                        code_q     <= code_next;
                        stat_space <= (code_next == CODE_OK) ? space - {14'd0, meta_len} : space;
                        state      <= S_STATUS;
                    end
                end
                S_STATUS: begin
                    if (stat_acc) begin
                        bytecnt <= '0;
                        if (code_q != CODE_OK) begin
                            pkt_err_cnt <= pkt_err_cnt + 32'd1;
                        end
                        case (code_q)
                            CODE_OK: begin
                                fwd   <= 1'b1;
                                state <= S_DATA;
                            end
                            CODE_NOCONN: begin
                                fwd   <= 1'b0;
                                state <= S_DATA;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_DATA: begin
                    if (beat_acc) begin
                        bytecnt <= bytecnt_final;
                        if (s_axis_tx_data_tlast) begin
                            if (bytecnt_final != {1'b0, len_q}) begin
                                len_mismatch <= 1'b1;
                            end
                            if (fwd) begin
                                pkt_ok_cnt <= pkt_ok_cnt + 32'd1;
                            end
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_app_tx_responder.sv
// Randomized scoreboard bench for tcp_app_tx_responder: a queue-based model of
// grants, buffer space and counters predicts every status word and forwarded beat.
module tb_tcp_app_tx_responder;

    localparam int NUM_SESSIONS = 16;
    localparam int BUF_BYTES    = 65536;
    localparam int MAX_LEN      = 1408;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic [15:0]  sess;
    } beat_t;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [15:0]  session_open = '0;
    logic [31:0]  meta_tdata = '0;
    logic         meta_tvalid = 1'b0;
    logic         meta_tready;
    logic [63:0]  st_tdata;
    logic         st_tvalid;
    logic         st_tready = 1'b0;
    logic [511:0] d_tdata = '0;
    logic [63:0]  d_tkeep = '0;
    logic         d_tlast = 1'b0;
    logic         d_tvalid = 1'b0;
    logic         d_tready;
    logic [511:0] out_tdata;
    logic [63:0]  out_tkeep;
    logic         out_tlast;
    logic         out_tvalid;
    logic         out_tready = 1'b1;
    logic [15:0]  out_session;
    logic         free_valid = 1'b0;
    logic [15:0]  free_bytes = '0;
    logic [31:0]  pkt_ok_cnt;
    logic [31:0]  pkt_err_cnt;
    logic         len_mismatch;

    int    tests = 0;
    int    fails = 0;
    int    m_space = BUF_BYTES;
    int    m_ok = 0;
    int    m_err = 0;
    bit    m_mis = 1'b0;
    int    acc_beats = 0;
    bit    rand_out = 1'b0;
    logic [63:0] stat_q[$];
    beat_t       beat_q[$];

    always #5 clk = ~clk;

    tcp_app_tx_responder #(
        .NUM_SESSIONS (NUM_SESSIONS),
        .BUF_BYTES    (BUF_BYTES),
        .MAX_LEN      (MAX_LEN)
    ) dut (
        .clk                       (clk),
        .aresetn                   (aresetn),
        .session_open              (session_open),
        .s_axis_tx_metadata_tdata  (meta_tdata),
        .s_axis_tx_metadata_tvalid (meta_tvalid),
        .s_axis_tx_metadata_tready (meta_tready),
        .m_axis_tx_status_tdata    (st_tdata),
        .m_axis_tx_status_tvalid   (st_tvalid),
        .m_axis_tx_status_tready   (st_tready),
        .s_axis_tx_data_tdata      (d_tdata),
        .s_axis_tx_data_tkeep      (d_tkeep),
        .s_axis_tx_data_tlast      (d_tlast),
        .s_axis_tx_data_tvalid     (d_tvalid),
        .s_axis_tx_data_tready     (d_tready),
        .m_axis_out_tdata          (out_tdata),
        .m_axis_out_tkeep          (out_tkeep),
        .m_axis_out_tlast          (out_tlast),
        .m_axis_out_tvalid         (out_tvalid),
        .m_axis_out_tready         (out_tready),
        .m_out_session             (out_session),
        .free_valid                (free_valid),
        .free_bytes                (free_bytes),
        .pkt_ok_cnt                (pkt_ok_cnt),
        .pkt_err_cnt               (pkt_err_cnt),
        .len_mismatch              (len_mismatch)
    );

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeoutFail(input string nm);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got timeout expected handshake", nm);
    endtask

    function automatic logic [1:0] expCode(input int s, input int l);
        if (l == 0 || l > MAX_LEN) return 2'd3;
        if (s >= NUM_SESSIONS || !session_open[s]) return 2'd1;
        if (l > m_space) return 2'd2;
        return 2'd0;
    endfunction

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_ok_cnt"}, 64'(pkt_ok_cnt), 64'(m_ok));
        checkOutput({tag, "_err_cnt"}, 64'(pkt_err_cnt), 64'(m_err));
        checkOutput({tag, "_len_mismatch"}, 64'(len_mismatch), 64'(m_mis));
    endtask

    task automatic freeBytes(input int b);
        free_valid = 1'b1;
        free_bytes = 16'(b);
        @(posedge clk);
        #1;
        free_valid = 1'b0;
        m_space = (m_space + b > BUF_BYTES) ? BUF_BYTES : m_space + b;
    endtask

    // One full transaction; hold keeps data TVALID up across a rejected grant,
    // abort_after >= 0 pulls reset after that many accepted beats.
    task automatic applyStimulus(input int sess, input int len, input int sent,
                                 input int stall, input int abort_after, input bit hold);
        logic [1:0]  code;
        logic [63:0] exp_st;
        beat_t       bt;
        bit          ok;
        int          sp, nbeats, rem, stalled, acc0;
        code   = expCode(sess, len);
        sp     = (code == 2'd0) ? m_space - len : m_space;
        exp_st = {code, 30'(sp), 16'(len), 16'(sess)};
        acc0   = acc_beats;
        if (hold) begin
            d_tvalid = 1'b1;
            d_tkeep  = '1;
            d_tlast  = 1'b1;
        end
        meta_tdata  = {16'(len), 16'(sess)};
        meta_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (meta_tready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        meta_tvalid = 1'b0;
        if (!ok) begin
            timeoutFail("meta_accept");
            d_tvalid = 1'b0;
            return;
        end
        stat_q.push_back(exp_st);
        if (code == 2'd0) m_space -= len;

        st_tready = (stall == 0);
        ok = 1'b0;
        stalled = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (st_tvalid) begin
                if (st_tready) ok = 1'b1;
                else begin
                    checkOutput("status_stable", st_tdata, exp_st);
                    stalled++;
                end
            end
            @(posedge clk);
            #1;
            if (stalled >= stall) st_tready = 1'b1;
        end
        st_tready = 1'b0;
        if (!ok) begin
            timeoutFail("status_accept");
            d_tvalid = 1'b0;
            return;
        end
        if (code != 2'd0) m_err++;

        if (code >= 2'd2) begin
            if (hold) begin
                repeat (3) @(posedge clk);
                #1;
                d_tvalid = 1'b0;
                checkOutput("held_off_beats", 64'(acc_beats - acc0), 64'd0);
            end
        end else begin
            nbeats = (sent + 63) / 64;
            for (int b = 0; b < nbeats; b++) begin
                rem     = (b == nbeats - 1) ? sent - 64 * b : 64;
                bt.keep = (rem == 64) ? '1 : ((64'd1 << rem) - 64'd1);
                for (int k = 0; k < 16; k++) bt.data[32*k +: 32] = $urandom;
                bt.last = (b == nbeats - 1);
                bt.sess = 16'(sess);
                d_tdata  = bt.data;
                d_tkeep  = bt.keep;
                d_tlast  = bt.last;
                d_tvalid = 1'b1;
                if (code == 2'd0) beat_q.push_back(bt);
                ok = 1'b0;
                for (int c = 0; c < 300 && !ok; c++) begin
                    @(negedge clk);
                    if (d_tready) ok = 1'b1;
                    @(posedge clk);
                    #1;
                end
                if (!ok) begin
                    timeoutFail("data_accept");
                    d_tvalid = 1'b0;
                    return;
                end
                if (abort_after >= 0 && b + 1 == abort_after) begin
                    d_tvalid = 1'b0;
                    aresetn  = 1'b0;
                    @(negedge clk);
                    checkOutput("rst_meta_tready", 64'(meta_tready), 64'd0);
                    checkOutput("rst_status_tvalid", 64'(st_tvalid), 64'd0);
                    checkOutput("rst_data_tready", 64'(d_tready), 64'd0);
                    checkOutput("rst_out_tvalid", 64'(out_tvalid), 64'd0);
                    repeat (2) @(posedge clk);
                    #1;
                    aresetn = 1'b1;
                    m_space = BUF_BYTES;
                    m_ok    = 0;
                    m_err   = 0;
                    m_mis   = 1'b0;
                    stat_q.delete();
                    beat_q.delete();
                    return;
                end
            end
            d_tvalid = 1'b0;
            checkOutput("beats_accepted", 64'(acc_beats - acc0), 64'(nbeats));
            if (sent != len) m_mis = 1'b1;
            if (code == 2'd0) m_ok++;
        end
        @(posedge clk);
        #1;
        checkCounters("txn");
    endtask

    // Scoreboard monitor: pops the expected status word / beat at each DUT handshake.
    always @(negedge clk) begin
        beat_t exp_b;
        if (aresetn) begin
            if (st_tvalid && st_tready) begin
                if (stat_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL status_unexpected: got %0h expected none", st_tdata);
                end else begin
                    checkOutput("status_word", st_tdata, stat_q.pop_front());
                end
            end
            if (out_tvalid && out_tready) begin
                tests++;
                if (beat_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL out_unexpected: got keep %0h session %0d expected no beat", out_tkeep, out_session);
                end else begin
                    exp_b = beat_q.pop_front();
                    if ({out_tdata, out_tkeep, out_tlast, out_session} !== exp_b) begin
                        fails++;
                        $display("[TB] FAIL out_beat: got keep %0h last %0b session %0d data %0h expected keep %0h last %0b session %0d data %0h",
                                 out_tkeep, out_tlast, out_session, out_tdata[63:0], exp_b.keep, exp_b.last, exp_b.sess, exp_b.data[63:0]);
                    end
                end
            end
            if (d_tvalid && d_tready) acc_beats++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_tready = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int s, l, snt, r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("inreset_meta_tready", 64'(meta_tready), 64'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(negedge clk);
        checkOutput("reset_meta_tready", 64'(meta_tready), 64'd1);
        checkOutput("reset_status_tvalid", 64'(st_tvalid), 64'd0);
        checkOutput("reset_data_tready", 64'(d_tready), 64'd0);
        checkOutput("reset_out_tvalid", 64'(out_tvalid), 64'd0);
        checkOutput("reset_out_session", 64'(out_session), 64'd0);
        checkCounters("reset");
        @(posedge clk);
        #1;

        session_open = 16'h0008;
        applyStimulus(3, 64, 64, 0, -1, 1'b0);
        applyStimulus(20, 64, 64, 0, -1, 1'b0);

        while (m_space >= MAX_LEN) applyStimulus(3, MAX_LEN, MAX_LEN, 0, -1, 1'b0);
        r = m_space + 1;
        applyStimulus(3, r, r, 0, -1, 1'b0);
        freeBytes(MAX_LEN);
        applyStimulus(3, r, r, 0, -1, 1'b0);
        freeBytes(60000);

        applyStimulus(3, 0, 0, 0, -1, 1'b1);
        applyStimulus(3, MAX_LEN + 1, 0, 0, -1, 1'b1);

        applyStimulus(3, 100, 68, 0, -1, 1'b0);
        applyStimulus(3, 64, 64, 0, -1, 1'b0);

        rand_out = 1'b1;
        applyStimulus(3, 320, 320, 5, -1, 1'b0);
        applyStimulus(3, 320, 320, 0, 2, 1'b0);
        checkCounters("after_abort");
        applyStimulus(3, MAX_LEN, MAX_LEN, 0, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            session_open = 16'($urandom);
            s = $urandom_range(0, 19);
            r = $urandom_range(0, 9);
            if (r == 0) l = 0;
            else if (r == 1) l = MAX_LEN + 1 + $urandom_range(0, 100);
            else l = $urandom_range(1, MAX_LEN);
            snt = ($urandom_range(0, 7) == 0 || l == 0 || l > MAX_LEN) ? $urandom_range(1, MAX_LEN) : l;
            applyStimulus(s, l, snt, $urandom_range(0, 3), -1, 1'b0);
            if ($urandom_range(0, 3) == 0) freeBytes($urandom_range(0, 4000));
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("status_queue_drained", 64'(stat_q.size()), 64'd0);
        checkOutput("beat_queue_drained", 64'(beat_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
